cmos_nvram_uploader: RTL and testbench

//  Reads the 4-bit Williams CMOS (high-score/settings NVRAM) back to the HPS over the hps_io ioctl upload path.
//  It is the reader counterpart of the ROM/NVRAM download writer (dn_addr/dn_data/dn_wr).
//  It packs two CMOS nibbles per upload byte and steals the CMOS read port only while an upload read is in flight.
//  It tracks whether the CPU has modified CMOS since the last complete save.
//  It sits in emu between hps_io and williams2, in the clk_sys (12 MHz) domain.

---
 rtl/cmos_nvram_uploader.sv | 131 +++++++++++++
 tb/tb_cmos_nvram_uploader.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/cmos_nvram_uploader.sv
// Purpose: reads 4-bit CMOS NVRAM back to hps_io as bytes (lo nibble = even address).
// Latency: ioctl_rd -> ioctl_din valid after 3+2*RAM_LATENCY cycles; out-of-range bytes after 2.
// Backpressure: ioctl_wait held high until the byte is valid; strobes while busy are dropped and flagged.
module cmos_nvram_uploader #(
    parameter int          CMOS_AW      = 10,
    parameter int          RAM_LATENCY  = 1,
    parameter logic [15:0] UPLOAD_INDEX = 16'd4
) (
    input  logic               clk_sys,
    input  logic               reset_n,
    input  logic               ioctl_upload,
    input  logic [15:0]        ioctl_index,
    input  logic               ioctl_rd,
    input  logic [24:0]        ioctl_addr,
    output logic [7:0]         ioctl_din,
    output logic               ioctl_wait,
    output logic [CMOS_AW-1:0] cmos_addr,
    output logic               cmos_rd,
    input  logic [3:0]         cmos_q,
    input  logic               cpu_cmos_we,
    output logic               nvram_dirty,
    output logic               upload_done,
    output logic               upload_err
);
    // Byte address width of the upload image.
    localparam int         BW       = CMOS_AW - 1;
    localparam logic [1:0] LAT_LAST = 2'(RAM_LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE, LO_ADDR, LO_WAIT, HI_ADDR, HI_WAIT, DONE
    } state_t;

    state_t        state, state_nxt;
    logic          sel, sel_q, sel_rise, sel_fall;
    logic          start, abort, in_range, lat_done, last_byte_done;
    logic [BW-1:0] byte_addr;
    logic [3:0]    lo;
    logic [1:0]    lat_cnt;
    logic          oor;
    logic          complete;

    assign sel       = ioctl_upload && (ioctl_index == UPLOAD_INDEX);
    assign sel_rise  = sel && !sel_q;
    assign sel_fall  = !sel && sel_q;
    assign in_range  = (ioctl_addr[24:BW] == '0);
    assign start     = (state == IDLE) && sel && ioctl_rd;
    assign abort     = (state != IDLE) && !sel;
    assign lat_done  = (lat_cnt == LAT_LAST);

    // Next-state: fixed nibble sequence, session loss overrides everything.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = in_range ? LO_ADDR : DONE;
            LO_ADDR: state_nxt = LO_WAIT;
            LO_WAIT: if (lat_done) state_nxt = HI_ADDR;
            HI_ADDR: state_nxt = HI_WAIT;
            HI_WAIT: if (lat_done) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    assign last_byte_done = (state == HI_WAIT) && (state_nxt == DONE) && (byte_addr == '1);

    // State register.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Read datapath: latch byte address, drive CMOS port, assemble and present the byte.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            byte_addr  <= '0;
            oor        <= 1'b0;
            lo         <= 4'h0;
            lat_cnt    <= 2'd0;
            ioctl_din  <= 8'h00;
            ioctl_wait <= 1'b0;
            cmos_addr  <= '0;
            cmos_rd    <= 1'b0;
        end else begin
            lat_cnt <= (state == LO_WAIT || state == HI_WAIT) ? lat_cnt + 2'd1 : 2'd0;
            cmos_rd <= (state_nxt == LO_ADDR) || (state_nxt == LO_WAIT) ||
                       (state_nxt == HI_ADDR) || (state_nxt == HI_WAIT);
            if (start) begin
                byte_addr  <= ioctl_addr[BW-1:0];
                oor        <= !in_range;
                ioctl_wait <= 1'b1;
                if (in_range) cmos_addr <= {ioctl_addr[BW-1:0], 1'b0};
            end
            if (state == LO_WAIT && state_nxt == HI_ADDR) begin
                lo        <= cmos_q;
                cmos_addr <= {byte_addr, 1'b1};
            end
            // In-range bytes are presented on entry to DONE, straight from the high nibble.
            if (state == HI_WAIT && state_nxt == DONE) begin
                ioctl_din  <= {cmos_q, lo};
                ioctl_wait <= 1'b0;
            end
            // Out-of-range bytes spend one cycle in DONE before being presented.
            if (state == DONE && !abort) begin
                if (oor) ioctl_din <= 8'hFF;
                ioctl_wait <= 1'b0;
            end
            if (abort) ioctl_wait <= 1'b0;
        end
    end

    // Session tracking: completion flag, dirty flag, done pulse and sticky busy error.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sel_q       <= 1'b0;
            complete    <= 1'b0;
            nvram_dirty <= 1'b0;
            upload_done <= 1'b0;
            upload_err  <= 1'b0;
        end else begin
            sel_q       <= sel;
            upload_done <= sel_fall && complete;
            if (sel_rise)            complete <= 1'b0;
            else if (last_byte_done) complete <= 1'b1;
            if (cpu_cmos_we)                nvram_dirty <= 1'b1;
            else if (sel_fall && complete)  nvram_dirty <= 1'b0;
            if ((state != IDLE) && sel && ioctl_rd) upload_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cmos_nvram_uploader.sv
module tb_cmos_nvram_uploader;
    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ioctl_upload = 1'b0;
    logic [15:0] ioctl_index = 16'd0;
    logic        ioctl_rd = 1'b0;
    logic [24:0] ioctl_addr = 25'd0;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait;
    logic [9:0]  cmos_addr;
    logic        cmos_rd;
    logic [3:0]  cmos_q = 4'h0;
    logic        cpu_cmos_we = 1'b0;
    logic        nvram_dirty;
    logic        upload_done;
    logic        upload_err;

    int total = 0;
    int bad   = 0;

    logic [3:0] mem [0:1023];

    cmos_nvram_uploader #(.CMOS_AW(10), .RAM_LATENCY(1), .UPLOAD_INDEX(16'd4)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index),
        .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr),
        .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait),
        .cmos_addr(cmos_addr), .cmos_rd(cmos_rd), .cmos_q(cmos_q),
        .cpu_cmos_we(cpu_cmos_we), .nvram_dirty(nvram_dirty),
        .upload_done(upload_done), .upload_err(upload_err)
    );

    always #5 clk_sys = ~clk_sys;

    // CMOS model: one-cycle registered read, nibble n holds n[3:0].
    always @(posedge clk_sys) cmos_q <= mem[cmos_addr];

    task automatic test_reset();
        #12;
        total++; if (ioctl_din !== 8'h00) begin bad++; $display("FAIL rst_din got=%h exp=00", ioctl_din); end
        total++; if (ioctl_wait !== 1'b0) begin bad++; $display("FAIL rst_wait got=%b exp=0", ioctl_wait); end
        total++; if (cmos_addr !== 10'd0) begin bad++; $display("FAIL rst_cmos_addr got=%h exp=0", cmos_addr); end
        total++; if (cmos_rd !== 1'b0) begin bad++; $display("FAIL rst_cmos_rd got=%b exp=0", cmos_rd); end
        total++; if ({nvram_dirty, upload_done, upload_err} !== 3'b000) begin
            bad++; $display("FAIL rst_flags got=%b exp=000", {nvram_dirty, upload_done, upload_err}); end
        @(negedge clk_sys); reset_n = 1'b1;
    endtask

    task automatic test_basic_read();
        logic exp_w;
        @(negedge clk_sys); ioctl_upload = 1'b1; ioctl_index = 16'd4;
        @(negedge clk_sys); ioctl_rd = 1'b1; ioctl_addr = 25'h3;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk_sys); ioctl_rd = 1'b0;
            exp_w = (c < 5);
            total++; if (ioctl_wait !== exp_w) begin bad++; $display("FAIL basic_wait c=%0d got=%b exp=%b", c, ioctl_wait, exp_w); end
            if (c == 1) begin
                total++; if (cmos_addr !== 10'd6 || cmos_rd !== 1'b1) begin bad++;
                    $display("FAIL basic_lo_addr got=%0d/%b exp=6/1", cmos_addr, cmos_rd); end
            end
            if (c == 3) begin
                total++; if (cmos_addr !== 10'd7 || cmos_rd !== 1'b1) begin bad++;
                    $display("FAIL basic_hi_addr got=%0d/%b exp=7/1", cmos_addr, cmos_rd); end
            end
            if (c == 5) begin
                total++; if (ioctl_din !== 8'h76 || cmos_rd !== 1'b0) begin bad++;
                    $display("FAIL basic_din got=%h/%b exp=76/0", ioctl_din, cmos_rd); end
            end
        end
        @(negedge clk_sys);
    endtask

    task automatic test_full_session();
        int n;
        int pulses;
        logic [7:0] e;
        cpu_cmos_we = 1'b1;
        @(negedge clk_sys); cpu_cmos_we = 1'b0;
        total++; if (nvram_dirty !== 1'b1) begin bad++; $display("FAIL dirty_set got=%b exp=1", nvram_dirty); end
        // Ending an incomplete session must not pulse or clear dirty.
        ioctl_upload = 1'b0;
        @(negedge clk_sys);
        @(negedge clk_sys);
        total++; if (upload_done !== 1'b0 || nvram_dirty !== 1'b1) begin bad++;
            $display("FAIL partial_end got=%b/%b exp=0/1", upload_done, nvram_dirty); end
        ioctl_upload = 1'b1;
        @(negedge clk_sys);
        for (int k = 0; k < 512; k++) begin
            ioctl_rd = 1'b1; ioctl_addr = 25'(k);
            @(negedge clk_sys); ioctl_rd = 1'b0;
            n = 1;
            while (ioctl_wait && n < 20) begin @(negedge clk_sys); n++; end
            e = 8'(((2 * k + 1) % 16) * 16 + (2 * k) % 16);
            total++; if (ioctl_din !== e || n != 5) begin bad++;
                $display("FAIL full_byte k=%0d got=%h cyc=%0d exp=%h cyc=5", k, ioctl_din, n, e); end
            @(negedge clk_sys);
        end
        ioctl_upload = 1'b0;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_sys);
            if (upload_done) pulses++;
            if (i == 0) begin
                total++; if (upload_done !== 1'b1 || nvram_dirty !== 1'b0) begin bad++;
                    $display("FAIL full_end got=%b/%b exp=1/0", upload_done, nvram_dirty); end
            end
        end
        total++; if (pulses != 1) begin bad++; $display("FAIL done_pulses got=%0d exp=1", pulses); end
        total++; if (upload_err !== 1'b0) begin bad++; $display("FAIL full_err got=%b exp=0", upload_err); end
    endtask

    task automatic test_out_of_range();
        logic [24:0] addrs [2];
        addrs[0] = 25'h200;
        addrs[1] = 25'h1000003;
        ioctl_upload = 1'b1;
        @(negedge clk_sys);
        for (int i = 0; i < 2; i++) begin
            ioctl_rd = 1'b1; ioctl_addr = addrs[i];
            @(negedge clk_sys); ioctl_rd = 1'b0;
            total++; if (ioctl_wait !== 1'b1 || cmos_rd !== 1'b0) begin bad++;
                $display("FAIL oor_c1 a=%h got=%b/%b exp=1/0", addrs[i], ioctl_wait, cmos_rd); end
            @(negedge clk_sys);
            total++; if (ioctl_wait !== 1'b0 || ioctl_din !== 8'hFF || cmos_rd !== 1'b0) begin bad++;
                $display("FAIL oor_c2 a=%h got=%b/%h/%b exp=0/ff/0", addrs[i], ioctl_wait, ioctl_din, cmos_rd); end
            @(negedge clk_sys);
        end
    endtask

    task automatic test_back_to_back();
        ioctl_rd = 1'b1; ioctl_addr = 25'h5;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk_sys);
            ioctl_rd = (c == 2);
            if (c == 2) ioctl_addr = 25'h7;
            if (c == 3) begin
                total++; if (upload_err !== 1'b1) begin bad++; $display("FAIL busy_err got=%b exp=1", upload_err); end
            end
            if (c == 5) begin
                total++; if (ioctl_din !== 8'hBA || ioctl_wait !== 1'b0) begin bad++;
                    $display("FAIL busy_din got=%h/%b exp=ba/0", ioctl_din, ioctl_wait); end
            end
            if (c >= 6) begin
                total++; if (ioctl_wait !== 1'b0 || cmos_rd !== 1'b0 || cmos_addr !== 10'd11) begin bad++;
                    $display("FAIL busy_no_second c=%0d got=%b/%b/%0d exp=0/0/11", c, ioctl_wait, cmos_rd, cmos_addr); end
            end
        end
    endtask

    task automatic test_abort();
        cpu_cmos_we = 1'b1;
        @(negedge clk_sys); cpu_cmos_we = 1'b0;
        ioctl_rd = 1'b1; ioctl_addr = 25'h2;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk_sys);
            ioctl_rd = 1'b0;
            if (c == 3) ioctl_upload = 1'b0;
            if (c == 4) begin
                total++; if (ioctl_wait !== 1'b0 || cmos_rd !== 1'b0 || ioctl_din !== 8'hBA) begin bad++;
                    $display("FAIL abort got=%b/%b/%h exp=0/0/ba", ioctl_wait, cmos_rd, ioctl_din); end
            end
            if (c >= 4) begin
                total++; if (upload_done !== 1'b0 || nvram_dirty !== 1'b1) begin bad++;
                    $display("FAIL abort_flags c=%0d got=%b/%b exp=0/1", c, upload_done, nvram_dirty); end
            end
        end
    endtask

    task automatic test_set_wins();
        ioctl_upload = 1'b1;
        @(negedge clk_sys);
        ioctl_rd = 1'b1; ioctl_addr = 25'h1FF;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk_sys); ioctl_rd = 1'b0;
            if (c == 5) begin
                total++; if (ioctl_din !== 8'hFE || ioctl_wait !== 1'b0) begin bad++;
                    $display("FAIL last_byte got=%h/%b exp=fe/0", ioctl_din, ioctl_wait); end
            end
        end
        ioctl_upload = 1'b0; cpu_cmos_we = 1'b1;
        @(negedge clk_sys); cpu_cmos_we = 1'b0;
        total++; if (upload_done !== 1'b1 || nvram_dirty !== 1'b1) begin bad++;
            $display("FAIL set_wins got=%b/%b exp=1/1", upload_done, nvram_dirty); end
    endtask

    task automatic test_reset_mid_read();
        ioctl_upload = 1'b1;
        @(negedge clk_sys);
        ioctl_rd = 1'b1; ioctl_addr = 25'h3;
        @(negedge clk_sys); ioctl_rd = 1'b0;
        @(negedge clk_sys);
        total++; if (cmos_rd !== 1'b1 || ioctl_wait !== 1'b1) begin bad++;
            $display("FAIL pre_reset got=%b/%b exp=1/1", cmos_rd, ioctl_wait); end
        reset_n = 1'b0;
        #1;
        total++; if (ioctl_din !== 8'h00 || ioctl_wait !== 1'b0 || cmos_addr !== 10'd0 || cmos_rd !== 1'b0 ||
                     nvram_dirty !== 1'b0 || upload_done !== 1'b0 || upload_err !== 1'b0) begin bad++;
            $display("FAIL async_reset got=%h/%b/%0d/%b/%b/%b/%b exp=00/0/0/0/0/0/0",
                     ioctl_din, ioctl_wait, cmos_addr, cmos_rd, nvram_dirty, upload_done, upload_err); end
        @(negedge clk_sys); reset_n = 1'b1;
        @(negedge clk_sys);
        ioctl_rd = 1'b1; ioctl_addr = 25'h3;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk_sys); ioctl_rd = 1'b0;
        end
        total++; if (ioctl_din !== 8'h76 || ioctl_wait !== 1'b0) begin bad++;
            $display("FAIL post_reset_read got=%h/%b exp=76/0", ioctl_din, ioctl_wait); end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 4'(i);
        test_reset();
        test_basic_read();
        test_full_session();
        test_out_of_range();
        test_back_to_back();
        test_abort();
        test_set_wins();
        test_reset_mid_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
